// File: rtl/scan_index_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : scan_index_sequencer
// Description : Round-robin 3-bit select generator for a 3-to-8 decoder.
//               Visits the channels enabled in a mask, holding each one for
//               a programmable dwell, with registered step/wrap strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module scan_index_sequencer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [7:0]         mask,
  output logic [2:0]         sel,
  output logic               active,
  output logic               step,
  output logic               wrap
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t             r_state;
  logic [2:0]         r_sel;
  logic               r_active;
  logic               r_step;
  logic               r_wrap;
  logic [DWELL_W-1:0] r_cnt;

  state_t             w_state_n;
  logic [2:0]         w_sel_n;
  logic               w_active_n;
  logic               w_step_n;
  logic               w_wrap_n;
  logic [DWELL_W-1:0] w_cnt_n;

  logic [2:0]         w_low_idx;
  logic [2:0]         w_next_idx;
  logic               w_found;
  logic               w_mask_any;

  assign w_mask_any = |mask;

  // Lowest set mask bit: the starting channel whenever the scan (re)starts.
  always_comb begin
    w_low_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i]) w_low_idx = 3'(i);
    end
  end

  // Circular search from sel+1 through sel; the current channel is the last
  // candidate so a single-bit mask re-selects itself.
  always_comb begin
    w_next_idx = r_sel;
    w_found    = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      if (!w_found && mask[r_sel + 3'(i)]) begin
        w_next_idx = r_sel + 3'(i);
        w_found    = 1'b1;
      end
    end
  end

  // Next-state and next-output decode; strobes default low every cycle.
  always_comb begin
    w_state_n  = r_state;
    w_sel_n    = r_sel;
    w_active_n = r_active;
    w_step_n   = 1'b0;
    w_wrap_n   = 1'b0;
    w_cnt_n    = r_cnt;
    case (r_state)
      S_IDLE: begin
        w_active_n = 1'b0;
        if (en && w_mask_any) begin
          w_state_n  = S_RUN;
          w_sel_n    = w_low_idx;
          w_active_n = 1'b1;
          w_step_n   = 1'b1;
          w_cnt_n    = dwell;
        end
      end
      S_RUN: begin
        if (!en || !w_mask_any) begin
          w_state_n  = S_IDLE;
          w_active_n = 1'b0;
        end else if (r_cnt != '0) begin
          w_cnt_n = r_cnt - DWELL_W'(1);
        end else begin
          w_sel_n  = w_next_idx;
          w_step_n = 1'b1;
          w_wrap_n = (w_next_idx <= r_sel);
          w_cnt_n  = dwell;
        end
      end
      default: begin
        w_state_n  = S_IDLE;
        w_active_n = 1'b0;
      end
    endcase
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_sel    <= 3'd0;
      r_active <= 1'b0;
      r_step   <= 1'b0;
      r_wrap   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_n;
      r_sel    <= w_sel_n;
      r_active <= w_active_n;
      r_step   <= w_step_n;
      r_wrap   <= w_wrap_n;
      r_cnt    <= w_cnt_n;
    end
  end

  assign sel    = r_sel;
  assign active = r_active;
  assign step   = r_step;
  assign wrap   = r_wrap;

endmodule
`default_nettype wire
